// File: rtl/carry_chains_pkg.sv
// Shared types and helpers for the carry-chain event decoder.
package carry_chains_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Index width for a vector of `value` bits, never less than 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/carry_chain_prio_enc.sv
// Lowest-set-bit encoder: two's-complement isolate maps onto the carry chain.
module carry_chain_prio_enc
    import carry_chains_pkg::*;
#(
    parameter  int WIDTH = 12,
    localparam int IDX_W = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot,
    output logic             single,
    output logic             any
);

    assign onehot = vec & (~vec + WIDTH'(1));
    assign any    = |vec;
    assign single = any && ((vec & (vec - WIDTH'(1))) == '0);

    // onehot has at most one bit set, so the last match is the only match.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/carry_chain_event_decoder.sv
// Captures an event vector and streams out the index of each set bit, lowest first.
//   state | meaning
//   IDLE  | nothing pending, waiting for a vector
//   EMIT  | presenting one pending index per accepted transfer
module carry_chain_event_decoder
    import carry_chains_pkg::*;
#(
    parameter  int WIDTH = 12,
    parameter  int MERGE = 0,
    localparam int IDX_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] user_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] idx_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam logic MERGE_EN = (MERGE != 0);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] pres_mask;
    logic [WIDTH-1:0] retire_mask;
    logic [WIDTH-1:0] accept_bits;
    logic             accept;
    logic             retire;
    logic             load_out;

    logic [IDX_W-1:0] enc_idx;
    logic [WIDTH-1:0] enc_onehot;
    logic             enc_single;
    logic             enc_any;

    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && out_ready;

    // In IDLE pending is zero and nothing retires, so one expression covers load and merge.
    assign retire_mask  = retire ? pres_mask : '0;
    assign accept_bits  = accept ? user_in : '0;
    assign pending_next = (pending & ~retire_mask) | accept_bits;

    // Presented index only moves on a retire or when nothing is presented.
    assign load_out = retire || !out_valid;

    carry_chain_prio_enc #(
        .WIDTH (WIDTH)
    ) u_prio_enc (
        .vec    (pending_next),
        .idx    (enc_idx),
        .onehot (enc_onehot),
        .single (enc_single),
        .any    (enc_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = enc_any ? EMIT : IDLE;
            EMIT:    state_next = enc_any ? EMIT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == EMIT);
        busy      = (state == EMIT);
        in_ready  = rst_n && ((state == IDLE) || MERGE_EN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= '0;
            pres_mask <= '0;
            idx_out   <= '0;
            out_last  <= 1'b0;
        end else begin
            pending <= pending_next;
            if (load_out) begin
                idx_out   <= enc_idx;
                out_last  <= enc_single;
                pres_mask <= enc_onehot;
            end
        end
    end

endmodule
